// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS pipeline slice.
//   XLEN        datapath width
//   NOP_INST    bubble instruction (sll $0,$0,0)
//   RESET_PC    default PC after reset
//   OFFSET_*    bit range of the 16-bit branch offset inside an instruction
package cpu_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned OFFSET_MSB = 15;
  localparam int unsigned OFFSET_LSB = 0;
endpackage

// File: rtl/if_id_fetch_stage_pc_reg.sv
// Program counter register.
//   clk, rst  : clock, asynchronous active-high reset (loads RESET_PC)
//   en        : load enable (deasserted while the pipeline is stalled)
//   next_pc   : value loaded on an enabled edge
//   pc        : current program counter
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else if (en)
      pc <= next_pc;
  end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
//   clk, rst           : clock, asynchronous active-high reset
//   stall              : hold PC and IF/ID register; redirects ignored
//   branch_taken/_dest : taken branch from ID and its target
//   jump/jump_dest     : jump from ID and its target (wins over branch)
//   imem_inst          : combinational instruction read of imem_addr
//   imem_addr          : current PC
//   id_inst, id_pc_4   : registered instruction and its PC+4
//   id_offset          : id_inst[15:0] for the branch adder
//   id_valid           : 0 while ID holds an injected bubble
//   misalign_err       : one-cycle pulse after a misaligned redirect
// Macro PC_ALIGN_CHECK_EN: when defined, redirect targets are forced to word
// alignment and misalign_err is driven; otherwise targets load unmodified and
// misalign_err is tied 0.
module if_id_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_dest,
  input  logic        jump,
  input  logic [31:0] jump_dest,
  input  logic [31:0] imem_inst,
  output logic [31:0] imem_addr,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc_4,
  output logic [15:0] id_offset,
  output logic        id_valid,
  output logic        misalign_err
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_4;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            redirect;

  always_comb begin
    pc_4     = pc + 32'd4;
    redirect = jump | branch_taken;
    target   = jump ? jump_dest : branch_dest;
`ifdef PC_ALIGN_CHECK_EN
    next_pc  = redirect ? {target[XLEN-1:2], 2'b00} : pc_4;
`else
    next_pc  = redirect ? target : pc_4;
`endif
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .en      (~stall),
    .next_pc (next_pc),
    .pc      (pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_inst  <= NOP_INST;
      id_pc_4  <= '0;
      id_valid <= 1'b0;
    end else if (!stall) begin
      if (redirect) begin
        id_inst  <= NOP_INST;
        id_pc_4  <= '0;
        id_valid <= 1'b0;
      end else begin
        id_inst  <= imem_inst;
        id_pc_4  <= pc_4;
        id_valid <= 1'b1;
      end
    end
  end

  assign id_offset = id_inst[OFFSET_MSB:OFFSET_LSB];

`ifdef PC_ALIGN_CHECK_EN
  // Recomputed every edge so the flag never lasts more than one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      misalign_err <= 1'b0;
    else
      misalign_err <= ~stall & redirect & (target[1:0] != 2'b00);
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
module tb_if_id_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_dest;
  logic        jump;
  logic [31:0] jump_dest;
  logic [31:0] imem_inst;
  logic [31:0] imem_addr;
  logic [31:0] id_inst;
  logic [31:0] id_pc_4;
  logic [15:0] id_offset;
  logic        id_valid;
  logic        misalign_err;

  int vectors;
  int miscompares;

  if_id_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_dest  (branch_dest),
    .jump         (jump),
    .jump_dest    (jump_dest),
    .imem_inst    (imem_inst),
    .imem_addr    (imem_addr),
    .id_inst      (id_inst),
    .id_pc_4      (id_pc_4),
    .id_offset    (id_offset),
    .id_valid     (id_valid),
    .misalign_err (misalign_err)
  );

  // Instruction memory model: word at address a is 0x1000_00AA + a.
  assign imem_inst = 32'h1000_00AA + imem_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_dest = '0;
    jump = 1'b0;
    jump_dest = '0;
    tick();
    tick();
    check("rst_addr", imem_addr, 32'h0);
    check("rst_inst", id_inst, 32'h0);
    check("rst_pc4", id_pc_4, 32'h0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);

    // Free run
    rst = 1'b0;
    #1;
    check("post_rst_valid", {31'd0, id_valid}, 32'd0);
    check("post_rst_addr", imem_addr, 32'h0);
    tick();
    check("run1_addr", imem_addr, 32'h4);
    check("run1_inst", id_inst, 32'h1000_00AA);
    check("run1_pc4", id_pc_4, 32'h4);
    check("run1_valid", {31'd0, id_valid}, 32'd1);
    check("run1_offset", {16'd0, id_offset}, 32'h0000_00AA);
    tick();
    check("run2_addr", imem_addr, 32'h8);
    check("run2_inst", id_inst, 32'h1000_00AE);
    check("run2_pc4", id_pc_4, 32'h8);
    tick();
    check("run3_addr", imem_addr, 32'hC);
    tick();
    check("run4_addr", imem_addr, 32'h10);
    check("run4_inst", id_inst, 32'h1000_00B6);
    check("run4_pc4", id_pc_4, 32'h10);

    // Taken branch at pc=0x10
    branch_taken = 1'b1;
    branch_dest = 32'h0000_0040;
    tick();
    branch_taken = 1'b0;
    check("br_addr", imem_addr, 32'h40);
    check("br_inst", id_inst, 32'h0);
    check("br_pc4", id_pc_4, 32'h0);
    check("br_valid", {31'd0, id_valid}, 32'd0);
    tick();
    check("br_next_addr", imem_addr, 32'h44);
    check("br_next_inst", id_inst, 32'h1000_00EA);
    check("br_next_pc4", id_pc_4, 32'h44);
    check("br_next_valid", {31'd0, id_valid}, 32'd1);

    // Stall with branch pending
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_dest = 32'h0000_0080;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", imem_addr, 32'h44);
      check("stall_inst", id_inst, 32'h1000_00EA);
      check("stall_pc4", id_pc_4, 32'h44);
      check("stall_valid", {31'd0, id_valid}, 32'd1);
    end
    stall = 1'b0;
    tick();
    branch_taken = 1'b0;
    check("unstall_addr", imem_addr, 32'h80);
    check("unstall_valid", {31'd0, id_valid}, 32'd0);

    // Jump beats branch
    jump = 1'b1;
    jump_dest = 32'h0000_0100;
    branch_taken = 1'b1;
    branch_dest = 32'h0000_0200;
    tick();
    branch_taken = 1'b0;
    check("prio_addr", imem_addr, 32'h100);
    check("prio_inst", id_inst, 32'h0);

    // PC wrap
    jump_dest = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    check("wrap_jaddr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc4", id_pc_4, 32'h0);
    check("wrap_inst", id_inst, 32'h1000_00A6);
    check("wrap_valid", {31'd0, id_valid}, 32'd1);
    tick();
    check("wrap_next_addr", imem_addr, 32'h4);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_addr", imem_addr, 32'h0);
    check("arst_inst", id_inst, 32'h0);
    check("arst_pc4", id_pc_4, 32'h0);
    check("arst_valid", {31'd0, id_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_rel_addr", imem_addr, 32'h4);
    check("arst_rel_inst", id_inst, 32'h1000_00AA);

    // Misaligned redirect target
    branch_taken = 1'b1;
    branch_dest = 32'h0000_0043;
    tick();
    branch_taken = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    check("mis_addr", imem_addr, 32'h40);
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_valid", {31'd0, id_valid}, 32'd0);
    tick();
    check("mis_clr_err", {31'd0, misalign_err}, 32'd0);
    check("mis_next_addr", imem_addr, 32'h44);
`else
    check("mis_addr", imem_addr, 32'h43);
    check("mis_err", {31'd0, misalign_err}, 32'd0);
    check("mis_valid", {31'd0, id_valid}, 32'd0);
    tick();
    check("mis_clr_err", {31'd0, misalign_err}, 32'd0);
    check("mis_next_addr", imem_addr, 32'h47);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
